// File: rtl/symbol_feeder.sv
// symbol_feeder: circular FIFO of 2-bit symbols feeding a registered, idle-padded
// symbol stream, with pause, synchronous flush and a sticky overflow flag.
module symbol_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     pause,
    input  logic                     flush,
    output logic [1:0]               num,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_num;
    logic          r_drop;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;

    // in_ready also drops while reset is held so nothing is accepted
    always_comb begin
        w_ready = !reset && (r_count != FULL) && !flush;
        w_push  = in_valid && w_ready;
        w_pop   = (r_count != '0) && !pause && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_num    <= 2'd0;
            r_drop   <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_num    <= 2'd0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_num   <= w_pop ? r_mem[r_rd_ptr] : 2'd0;
            if (in_valid && !w_ready)
                r_drop <= 1'b1;
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_data;
    end

    assign in_ready = w_ready;
    assign num      = r_num;
    assign count    = r_count;
    assign drop     = r_drop;
endmodule

// File: tb/tb_symbol_feeder.sv
// tb_symbol_feeder: directed checks of the symbol FIFO feeder at DEPTH=4.
module tb_symbol_feeder;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       pause;
    logic       flush;
    logic [1:0] num;
    logic [2:0] count;
    logic       drop;
    int n_tests = 0;
    int n_fail  = 0;

    symbol_feeder #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pause(pause), .flush(flush), .num(num),
        .count(count), .drop(drop)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; in_data = 2'd2; pause = 1'b0; flush = 1'b0;
        #3;
        n_tests++; if (num !== 2'd0) begin n_fail++; $display("FAIL reset num: got %0d want 0", num); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset count: got %0d want 0", count); end
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset drop: got %0d want 0", drop); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %0d want 0", in_ready); end
        tick; tick;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset held count: got %0d want 0", count); end
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset held drop: got %0d want 0", drop); end
        in_valid = 1'b0; reset = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release in_ready: got %0d want 1", in_ready); end
    endtask

    task automatic test_stream;
        logic [1:0] din [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        logic       vin [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0] en  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [2:0] ec  [5] = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
        pause = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = vin[i]; in_data = din[i];
            tick;
            n_tests++; if (num !== en[i]) begin n_fail++; $display("FAIL stream num[%0d]: got %0d want %0d", i, num, en[i]); end
            n_tests++; if (count !== ec[i]) begin n_fail++; $display("FAIL stream count[%0d]: got %0d want %0d", i, count, ec[i]); end
        end
    endtask

    task automatic test_flush;
        pause = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin in_data = 2'(i); tick; end
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush pre count: got %0d want 3", count); end
        flush = 1'b1; in_data = 2'd2; pause = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush in_ready: got %0d want 0", in_ready); end
        tick;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush count: got %0d want 0", count); end
        n_tests++; if (num !== 2'd0) begin n_fail++; $display("FAIL flush num: got %0d want 0", num); end
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL flush drop: got %0d want 0", drop); end
        flush = 1'b0; in_valid = 1'b0;
        tick;
        n_tests++; if (num !== 2'd0) begin n_fail++; $display("FAIL post-flush num: got %0d want 0", num); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL post-flush count: got %0d want 0", count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post-flush in_ready: got %0d want 1", in_ready); end
    endtask

    task automatic test_pause;
        logic [1:0] din [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic [1:0] en  [5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
        logic [2:0] ec  [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        pause = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin in_data = din[i]; tick; end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL pause count: got %0d want 4", count); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL pause in_ready: got %0d want 0", in_ready); end
        n_tests++; if (num !== 2'd0) begin n_fail++; $display("FAIL pause num: got %0d want 0", num); end
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL pause pre-drop: got %0d want 0", drop); end
        in_data = 2'd2;
        tick;
        n_tests++; if (drop !== 1'b1) begin n_fail++; $display("FAIL pause drop: got %0d want 1", drop); end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL pause overflow count: got %0d want 4", count); end
        in_valid = 1'b0; pause = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_tests++; if (num !== en[i]) begin n_fail++; $display("FAIL drain num[%0d]: got %0d want %0d", i, num, en[i]); end
            n_tests++; if (count !== ec[i]) begin n_fail++; $display("FAIL drain count[%0d]: got %0d want %0d", i, count, ec[i]); end
        end
    endtask

    task automatic test_reset_mid;
        pause = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin in_data = 2'(i); tick; end
        in_valid = 1'b0; pause = 1'b0;
        tick;
        n_tests++; if (num !== 2'd1) begin n_fail++; $display("FAIL mid pre num: got %0d want 1", num); end
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid pre count: got %0d want 2", count); end
        #2 reset = 1'b1;
        #1;
        n_tests++; if (num !== 2'd0) begin n_fail++; $display("FAIL mid reset num: got %0d want 0", num); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid reset count: got %0d want 0", count); end
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL mid reset drop: got %0d want 0", drop); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid reset in_ready: got %0d want 0", in_ready); end
        #2 reset = 1'b0;
        in_valid = 1'b1; in_data = 2'd3;
        tick;
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL mid push count: got %0d want 1", count); end
        in_valid = 1'b0;
        tick;
        n_tests++; if (num !== 2'd3) begin n_fail++; $display("FAIL mid first num: got %0d want 3", num); end
        tick;
        n_tests++; if (num !== 2'd0) begin n_fail++; $display("FAIL mid idle num: got %0d want 0", num); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid idle count: got %0d want 0", count); end
    endtask

    task automatic test_full_stream;
        logic [1:0] fill [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic [1:0] din  [7] = '{2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        logic       vin  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0] en   [7] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [2:0] ec   [7] = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        pause = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin in_data = fill[i]; tick; end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL full fill count: got %0d want 4", count); end
        pause = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = vin[i]; in_data = din[i];
            tick;
            n_tests++; if (num !== en[i]) begin n_fail++; $display("FAIL full num[%0d]: got %0d want %0d", i, num, en[i]); end
            n_tests++; if (count !== ec[i]) begin n_fail++; $display("FAIL full count[%0d]: got %0d want %0d", i, count, ec[i]); end
            if (i == 0) begin
                n_tests++; if (drop !== 1'b1) begin n_fail++; $display("FAIL full drop: got %0d want 1", drop); end
            end
        end
    endtask

    task automatic test_wrap;
        logic [1:0] sym [10] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
        int mq[$];
        int mcount = 0;
        int k = 0;
        int got = 0;
        int exp_num;
        logic mpush, mpop;
        for (int c = 0; c < 40; c++) begin
            pause    = (c < 6) || (c % 4 == 1) || (c >= 14 && c < 17);
            in_valid = (k < 10);
            in_data  = (k < 10) ? sym[k] : 2'd0;
            mpush = in_valid && (mcount != 4);
            mpop  = (mcount != 0) && !pause;
            tick;
            exp_num = 0;
            if (mpop) begin exp_num = mq.pop_front(); got++; end
            if (mpush) begin mq.push_back(int'(sym[k])); k++; end
            mcount = mcount + int'(mpush) - int'(mpop);
            n_tests++; if (num !== 2'(exp_num)) begin n_fail++; $display("FAIL wrap num[c%0d]: got %0d want %0d", c, num, exp_num); end
            n_tests++; if (count !== 3'(mcount)) begin n_fail++; $display("FAIL wrap count[c%0d]: got %0d want %0d", c, count, mcount); end
        end
        in_valid = 1'b0; pause = 1'b0;
        n_tests++; if (got != 10 || k != 10) begin n_fail++; $display("FAIL wrap totals: got %0d popped %0d pushed want 10 10", got, k); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_flush;
        test_pause;
        test_reset_mid;
        test_full_stream;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
